// File: rtl/wb_dual_master_arbiter.sv
// Round-robin Wishbone classic arbiter letting the ibus (read-only) and dbus
// masters share one slave port, with a bus-timeout watchdog.
module wb_dual_master_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic        wb_clk,
  input  logic        wb_rst,

  input  logic [31:0] wb_ibus_adr,
  input  logic        wb_ibus_cyc,
  input  logic        wb_ibus_stb,
  output logic [31:0] wb_ibus_rdt,
  output logic        wb_ibus_ack,
  output logic        wb_ibus_err,

  input  logic [31:0] wb_dbus_adr,
  input  logic [31:0] wb_dbus_dat,
  input  logic [3:0]  wb_dbus_sel,
  input  logic        wb_dbus_we,
  input  logic        wb_dbus_cyc,
  input  logic        wb_dbus_stb,
  output logic [31:0] wb_dbus_rdt,
  output logic        wb_dbus_ack,
  output logic        wb_dbus_err,

  output logic [31:0] wb_s_adr,
  output logic [31:0] wb_s_dat,
  output logic [3:0]  wb_s_sel,
  output logic        wb_s_we,
  output logic        wb_s_cyc,
  output logic        wb_s_stb,
  input  logic [31:0] wb_s_rdt,
  input  logic        wb_s_ack,
  input  logic        wb_s_err,

  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : {TO_W{1'b0}};

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [TO_W-1:0] toCnt_q, toCnt_d;

  logic reqI, reqD;
  logic slaveDone, atLimit;
  logic ownCyc, ownStb;
  logic fwdAck, fwdErr, finish;

  assign reqI      = wb_ibus_cyc & wb_ibus_stb;
  assign reqD      = wb_dbus_cyc & wb_dbus_stb;
  assign slaveDone = wb_s_ack | wb_s_err;
  assign atLimit   = (TIMEOUT > 0) && (toCnt_q == TO_LAST);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      toCnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      toCnt_q <= toCnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    toCnt_d     = toCnt_q;
    grant       = 2'b00;
    wb_s_adr    = '0;
    wb_s_dat    = '0;
    wb_s_sel    = '0;
    wb_s_we     = 1'b0;
    wb_s_cyc    = 1'b0;
    wb_s_stb    = 1'b0;
    wb_ibus_rdt = '0;
    wb_ibus_ack = 1'b0;
    wb_ibus_err = 1'b0;
    wb_dbus_rdt = '0;
    wb_dbus_ack = 1'b0;
    wb_dbus_err = 1'b0;
    ownCyc      = 1'b0;
    ownStb      = 1'b0;
    fwdAck      = 1'b0;
    fwdErr      = 1'b0;
    finish      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie the master that did not go last wins.
        if (reqI && reqD) begin
          state_d = last_q ? GNT_I : GNT_D;
        end else if (reqI) begin
          state_d = GNT_I;
        end else if (reqD) begin
          state_d = GNT_D;
        end
      end
      GNT_I: begin
        grant       = 2'b01;
        ownCyc      = wb_ibus_cyc;
        ownStb      = wb_ibus_stb;
        wb_s_adr    = wb_ibus_adr;
        wb_s_sel    = 4'hF;
        wb_ibus_rdt = wb_s_rdt;
      end
      GNT_D: begin
        grant       = 2'b10;
        ownCyc      = wb_dbus_cyc;
        ownStb      = wb_dbus_stb;
        wb_s_adr    = wb_dbus_adr;
        wb_s_dat    = wb_dbus_dat;
        wb_s_sel    = wb_dbus_sel;
        wb_s_we     = wb_dbus_we;
        wb_dbus_rdt = wb_s_rdt;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      // The limit cycle drops cyc from the counter alone, so no slave ack
      // can feed back combinationally into the slave strobe.
      wb_s_cyc = ownCyc & ~atLimit;
      wb_s_stb = ownStb & ~atLimit;
      if (!ownCyc) begin
        finish = 1'b1;
      end else begin
        fwdAck = wb_s_ack;
        fwdErr = wb_s_err | (atLimit & ~slaveDone);
        finish = slaveDone | atLimit;
      end
      if (finish) begin
        state_d = IDLE;
        last_d  = (state_q == GNT_D);
        toCnt_d = '0;
      end else if (TIMEOUT > 0) begin
        toCnt_d = toCnt_q + 1'b1;
      end
    end

    wb_ibus_ack = fwdAck & (state_q == GNT_I);
    wb_ibus_err = fwdErr & (state_q == GNT_I);
    wb_dbus_ack = fwdAck & (state_q == GNT_D);
    wb_dbus_err = fwdErr & (state_q == GNT_D);
  end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Self-checking bench for wb_dual_master_arbiter: behavioural slave plus
// per-master response scoreboards and a grant-order log.
module tb_wb_dual_master_arbiter;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] KEY     = 32'hDEADAEEF;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic [31:0] wb_ibus_adr = '0;
  logic        wb_ibus_cyc = 1'b0;
  logic        wb_ibus_stb = 1'b0;
  logic [31:0] wb_ibus_rdt;
  logic        wb_ibus_ack;
  logic        wb_ibus_err;
  logic [31:0] wb_dbus_adr = '0;
  logic [31:0] wb_dbus_dat = '0;
  logic [3:0]  wb_dbus_sel = '0;
  logic        wb_dbus_we  = 1'b0;
  logic        wb_dbus_cyc = 1'b0;
  logic        wb_dbus_stb = 1'b0;
  logic [31:0] wb_dbus_rdt;
  logic        wb_dbus_ack;
  logic        wb_dbus_err;
  logic [31:0] wb_s_adr;
  logic [31:0] wb_s_dat;
  logic [3:0]  wb_s_sel;
  logic        wb_s_we;
  logic        wb_s_cyc;
  logic        wb_s_stb;
  logic [31:0] wb_s_rdt;
  logic        wb_s_ack;
  logic        wb_s_err;
  logic [1:0]  grant;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] rdt;
  } expT;

  expT        expIq[$];
  expT        expDq[$];
  expT        eI, eD;
  logic [1:0] grantLog[$];
  logic [1:0] prevGrant = 2'b00;

  int vectors = 0;
  int miscompares = 0;
  int ackCntI = 0;
  int ackCntD = 0;

  int   slaveWait = 0;
  int   waitCnt = 0;
  logic slaveOn = 1'b1;
  logic slaveForce = 1'b0;
  logic slaveErrMode = 1'b0;
  logic slaveReady;

  wb_dual_master_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .wb_ibus_adr (wb_ibus_adr),
    .wb_ibus_cyc (wb_ibus_cyc),
    .wb_ibus_stb (wb_ibus_stb),
    .wb_ibus_rdt (wb_ibus_rdt),
    .wb_ibus_ack (wb_ibus_ack),
    .wb_ibus_err (wb_ibus_err),
    .wb_dbus_adr (wb_dbus_adr),
    .wb_dbus_dat (wb_dbus_dat),
    .wb_dbus_sel (wb_dbus_sel),
    .wb_dbus_we  (wb_dbus_we),
    .wb_dbus_cyc (wb_dbus_cyc),
    .wb_dbus_stb (wb_dbus_stb),
    .wb_dbus_rdt (wb_dbus_rdt),
    .wb_dbus_ack (wb_dbus_ack),
    .wb_dbus_err (wb_dbus_err),
    .wb_s_adr    (wb_s_adr),
    .wb_s_dat    (wb_s_dat),
    .wb_s_sel    (wb_s_sel),
    .wb_s_we     (wb_s_we),
    .wb_s_cyc    (wb_s_cyc),
    .wb_s_stb    (wb_s_stb),
    .wb_s_rdt    (wb_s_rdt),
    .wb_s_ack    (wb_s_ack),
    .wb_s_err    (wb_s_err),
    .grant       (grant)
  );

  always #5 wb_clk = ~wb_clk;

  // Slave answers after slaveWait stalled strobe cycles; read data is the address scrambled with KEY.
  assign slaveReady = wb_s_cyc & wb_s_stb & slaveOn & (waitCnt == slaveWait);
  assign wb_s_ack   = slaveForce | (slaveReady & ~slaveErrMode);
  assign wb_s_err   = slaveReady & slaveErrMode;
  assign wb_s_rdt   = wb_s_adr ^ KEY;

  always @(posedge wb_clk) begin
    if (wb_rst || !wb_s_cyc || wb_s_ack || wb_s_err) waitCnt <= 0;
    else if (wb_s_stb) waitCnt <= waitCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every master response is popped against the entry pushed when it was issued.
  always @(negedge wb_clk) begin
    if (wb_ibus_ack === 1'b1 || wb_ibus_err === 1'b1) begin
      if (wb_ibus_ack === 1'b1) ackCntI++;
      if (expIq.size() == 0) begin
        checkOutput("ibus_unexpected_rsp", 32'(wb_ibus_ack | wb_ibus_err), 32'd0);
      end else begin
        eI = expIq.pop_front();
        checkOutput("ibus_err", 32'(wb_ibus_err), 32'(eI.err));
        checkOutput("ibus_ack", 32'(wb_ibus_ack), 32'(!eI.err));
        if (eI.chk) checkOutput("ibus_rdt", wb_ibus_rdt, eI.rdt);
      end
    end
    if (wb_dbus_ack === 1'b1 || wb_dbus_err === 1'b1) begin
      if (wb_dbus_ack === 1'b1) ackCntD++;
      if (expDq.size() == 0) begin
        checkOutput("dbus_unexpected_rsp", 32'(wb_dbus_ack | wb_dbus_err), 32'd0);
      end else begin
        eD = expDq.pop_front();
        checkOutput("dbus_err", 32'(wb_dbus_err), 32'(eD.err));
        checkOutput("dbus_ack", 32'(wb_dbus_ack), 32'(!eD.err));
        if (eD.chk) checkOutput("dbus_rdt", wb_dbus_rdt, eD.rdt);
      end
    end
    if (grant !== 2'b00 && prevGrant === 2'b00) grantLog.push_back(grant);
    prevGrant = grant;
  end

  task automatic applyReset();
    wb_rst       = 1'b1;
    wb_ibus_cyc  = 1'b0;
    wb_ibus_stb  = 1'b0;
    wb_ibus_adr  = '0;
    wb_dbus_cyc  = 1'b0;
    wb_dbus_stb  = 1'b0;
    wb_dbus_adr  = '0;
    wb_dbus_dat  = '0;
    wb_dbus_sel  = '0;
    wb_dbus_we   = 1'b0;
    slaveOn      = 1'b1;
    slaveForce   = 1'b0;
    slaveErrMode = 1'b0;
    repeat (2) @(posedge wb_clk);
    #1;
    grantLog.delete();
    ackCntI = 0;
    ackCntD = 0;
    wb_rst  = 1'b0;
  endtask

  task automatic applyStimulus(input logic dReq, input logic [31:0] dAdr, input logic [31:0] dDat,
                               input logic [3:0] dSel, input logic dWe);
    wb_dbus_adr = dAdr;
    wb_dbus_dat = dDat;
    wb_dbus_sel = dSel;
    wb_dbus_we  = dWe;
    wb_dbus_cyc = dReq;
    wb_dbus_stb = dReq;
  endtask

  task automatic ibusRun(input logic [31:0] adr, input int n, input logic expErr);
    expT  e;
    logic done;
    for (int k = 0; k < n; k++) begin
      e.err = expErr;
      e.chk = !expErr;
      e.rdt = adr ^ KEY;
      expIq.push_back(e);
      wb_ibus_adr = adr;
      wb_ibus_cyc = 1'b1;
      wb_ibus_stb = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge wb_clk);
        done = (wb_ibus_ack === 1'b1) || (wb_ibus_err === 1'b1);
      end
      checkOutput("ibus_xfer_done", 32'(done), 32'd1);
      @(posedge wb_clk);
      #1;
    end
    wb_ibus_cyc = 1'b0;
    wb_ibus_stb = 1'b0;
  endtask

  task automatic dbusRun(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, input int n, input logic expErr);
    expT  e;
    logic done;
    for (int k = 0; k < n; k++) begin
      e.err = expErr;
      e.chk = !expErr && !we;
      e.rdt = adr ^ KEY;
      expDq.push_back(e);
      applyStimulus(1'b1, adr, dat, sel, we);
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge wb_clk);
        done = (wb_dbus_ack === 1'b1) || (wb_dbus_err === 1'b1);
      end
      checkOutput("dbus_xfer_done", 32'(done), 32'd1);
      @(posedge wb_clk);
      #1;
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expT e;
    logic found;

    // Held in reset: every output must be quiet.
    repeat (2) @(posedge wb_clk);
    @(negedge wb_clk);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_s_cyc", 32'(wb_s_cyc), 32'd0);
    checkOutput("rst_s_stb", 32'(wb_s_stb), 32'd0);
    checkOutput("rst_s_we", 32'(wb_s_we), 32'd0);
    checkOutput("rst_s_adr", wb_s_adr, 32'd0);
    checkOutput("rst_s_dat", wb_s_dat, 32'd0);
    checkOutput("rst_s_sel", 32'(wb_s_sel), 32'd0);
    checkOutput("rst_acks", 32'({wb_ibus_ack, wb_ibus_err, wb_dbus_ack, wb_dbus_err}), 32'd0);
    checkOutput("rst_rdt", wb_ibus_rdt | wb_dbus_rdt, 32'd0);

    // Single ibus read, zero-wait slave.
    applyReset();
    slaveWait = 0;
    e.err = 1'b0; e.chk = 1'b1; e.rdt = 32'hDEADBEEF;
    expIq.push_back(e);
    wb_ibus_adr = 32'h1000; wb_ibus_cyc = 1'b1; wb_ibus_stb = 1'b1;
    @(negedge wb_clk);
    checkOutput("t1_c1_grant", 32'(grant), 32'd0);
    @(posedge wb_clk); #1;
    @(negedge wb_clk);
    checkOutput("t1_c2_grant", 32'(grant), 32'd1);
    checkOutput("t1_c2_s_stb", 32'(wb_s_stb), 32'd1);
    checkOutput("t1_c2_s_adr", wb_s_adr, 32'h1000);
    checkOutput("t1_c2_s_we", 32'(wb_s_we), 32'd0);
    checkOutput("t1_c2_s_sel", 32'(wb_s_sel), 32'hF);
    checkOutput("t1_c2_iack", 32'(wb_ibus_ack), 32'd1);
    checkOutput("t1_c2_irdt", wb_ibus_rdt, 32'hDEADBEEF);
    checkOutput("t1_c2_dack", 32'(wb_dbus_ack), 32'd0);
    @(posedge wb_clk); #1;
    wb_ibus_cyc = 1'b0; wb_ibus_stb = 1'b0;
    @(negedge wb_clk);
    checkOutput("t1_c3_grant", 32'(grant), 32'd0);

    // Tie right after reset goes to dbus, then ibus; 1-wait slave.
    applyReset();
    slaveWait = 1;
    fork
      ibusRun(32'h2000, 1, 1'b0);
      dbusRun(32'h3000, 32'h12345678, 4'h3, 1'b1, 1, 1'b0);
      begin
        @(negedge wb_clk);
        checkOutput("t2_c1_grant", 32'(grant), 32'd0);
        @(negedge wb_clk);
        checkOutput("t2_c2_grant", 32'(grant), 32'd2);
        checkOutput("t2_c2_s_we", 32'(wb_s_we), 32'd1);
        checkOutput("t2_c2_s_dat", wb_s_dat, 32'h12345678);
        checkOutput("t2_c2_s_sel", 32'(wb_s_sel), 32'h3);
        checkOutput("t2_c2_s_adr", wb_s_adr, 32'h3000);
      end
    join
    checkOutput("t2_grant_count", 32'(grantLog.size()), 32'd2);
    if (grantLog.size() >= 2) begin
      checkOutput("t2_first_grant", 32'(grantLog[0]), 32'd2);
      checkOutput("t2_second_grant", 32'(grantLog[1]), 32'd1);
    end

    // Continuous requests from both masters alternate D,I,D,I,D,I.
    applyReset();
    slaveWait = 0;
    fork
      ibusRun(32'h4000, 3, 1'b0);
      dbusRun(32'h4100, 32'h0, 4'hF, 1'b0, 3, 1'b0);
    join
    checkOutput("t3_grant_count", 32'(grantLog.size()), 32'd6);
    for (int i = 0; i < 6 && i < grantLog.size(); i++)
      checkOutput($sformatf("t3_grant%0d", i), 32'(grantLog[i]), (i % 2 == 0) ? 32'd2 : 32'd1);
    checkOutput("t3_ibus_acks", 32'(ackCntI), 32'd3);
    checkOutput("t3_dbus_acks", 32'(ackCntD), 32'd3);

    // Dead slave: dbus times out on its 16th granted cycle, pending ibus follows.
    applyReset();
    slaveWait = 0;
    slaveOn   = 1'b0;
    fork
      ibusRun(32'h5000, 1, 1'b0);
      dbusRun(32'h5100, 32'h0, 4'hF, 1'b0, 1, 1'b1);
      begin
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
          @(negedge wb_clk);
          found = (grant === 2'b10);
        end
        checkOutput("t4_dbus_granted", 32'(found), 32'd1);
        repeat (14) @(negedge wb_clk);
        checkOutput("t4_cyc15_derr", 32'(wb_dbus_err), 32'd0);
        checkOutput("t4_cyc15_s_cyc", 32'(wb_s_cyc), 32'd1);
        @(negedge wb_clk);
        checkOutput("t4_cyc16_derr", 32'(wb_dbus_err), 32'd1);
        checkOutput("t4_cyc16_s_cyc", 32'(wb_s_cyc), 32'd0);
        checkOutput("t4_cyc16_s_stb", 32'(wb_s_stb), 32'd0);
        checkOutput("t4_cyc16_ierr", 32'(wb_ibus_err), 32'd0);
        slaveOn = 1'b1;
        @(negedge wb_clk);
        checkOutput("t4_idle_grant", 32'(grant), 32'd0);
        @(negedge wb_clk);
        checkOutput("t4_ibus_grant", 32'(grant), 32'd1);
      end
    join

    // dbus aborts mid-stall while the slave acks; ack must not reach dbus.
    applyReset();
    slaveWait = 10;
    fork
      ibusRun(32'h6000, 1, 1'b0);
      begin
        applyStimulus(1'b1, 32'h6100, 32'h0, 4'hF, 1'b0);
        @(negedge wb_clk);
        checkOutput("t5_c1_grant", 32'(grant), 32'd0);
        @(posedge wb_clk); #1;
        @(negedge wb_clk);
        checkOutput("t5_c2_grant", 32'(grant), 32'd2);
        @(posedge wb_clk); #1;
        @(posedge wb_clk); #1;
        @(posedge wb_clk); #1;
        applyStimulus(1'b0, 32'h6100, 32'h0, 4'hF, 1'b0);
        slaveForce = 1'b1;
        @(negedge wb_clk);
        checkOutput("t5_c5_s_cyc", 32'(wb_s_cyc), 32'd0);
        checkOutput("t5_c5_s_stb", 32'(wb_s_stb), 32'd0);
        checkOutput("t5_c5_dack", 32'(wb_dbus_ack), 32'd0);
        checkOutput("t5_c5_iack", 32'(wb_ibus_ack), 32'd0);
        @(posedge wb_clk); #1;
        slaveForce = 1'b0;
        @(negedge wb_clk);
        checkOutput("t5_c6_grant", 32'(grant), 32'd0);
        @(negedge wb_clk);
        checkOutput("t5_c7_grant", 32'(grant), 32'd1);
      end
    join
    checkOutput("t5_dbus_acks", 32'(ackCntD), 32'd0);

    // Reset lands on the edge that closes an acked dbus transfer.
    applyReset();
    slaveWait = 2;
    e.err = 1'b0; e.chk = 1'b1; e.rdt = 32'h7000 ^ KEY;
    expDq.push_back(e);
    applyStimulus(1'b1, 32'h7000, 32'h0, 4'hF, 1'b0);
    @(posedge wb_clk); #1;
    @(negedge wb_clk);
    checkOutput("t6_c2_grant", 32'(grant), 32'd2);
    @(posedge wb_clk); #1;
    @(posedge wb_clk); #1;
    wb_rst = 1'b1;
    @(negedge wb_clk);
    checkOutput("t6_c4_dack", 32'(wb_dbus_ack), 32'd1);
    @(posedge wb_clk); #1;
    @(negedge wb_clk);
    checkOutput("t6_post_grant", 32'(grant), 32'd0);
    checkOutput("t6_post_acks", 32'({wb_ibus_ack, wb_dbus_ack}), 32'd0);
    checkOutput("t6_post_s_cyc", 32'(wb_s_cyc), 32'd0);
    @(posedge wb_clk); #1;
    wb_rst = 1'b0;
    grantLog.delete();
    fork
      ibusRun(32'h7100, 1, 1'b0);
      dbusRun(32'h7200, 32'h0, 4'hF, 1'b0, 1, 1'b0);
      begin
        @(negedge wb_clk);
        @(negedge wb_clk);
        checkOutput("t6_tie_grant", 32'(grant), 32'd2);
      end
    join

    // Slave error is routed only to the granted dbus.
    applyReset();
    slaveWait    = 0;
    slaveErrMode = 1'b1;
    dbusRun(32'h8000, 32'h0, 4'hF, 1'b0, 1, 1'b1);
    slaveErrMode = 1'b0;
    ibusRun(32'h8100, 1, 1'b0);

    repeat (2) @(negedge wb_clk);
    checkOutput("ibus_queue_empty", 32'(expIq.size()), 32'd0);
    checkOutput("dbus_queue_empty", 32'(expDq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_dual_master_arbiter.md
Name: wb_dual_master_arbiter

Overview:
Two-master, one-slave Wishbone classic arbiter. It lets the core's instruction bus (ibus, read-only) and data bus (dbus, read/write) share a single slave port, for example a unified memory or a shared peripheral segment.
- Grants are round-robin and registered; the grant is held for a whole single transfer.
- A bus-timeout watchdog returns err so a hung slave cannot lock the core.
- Sits between the processor's bus masters and the interconnect slave port.

Parameters:
- TIMEOUT, 1024: granted cycles without slave ack/err before the arbiter forces err. 0 disables the watchdog.
- TO_W, $clog2(TIMEOUT+1) (minimum 1): timeout counter width. Derived; not overridden.

Ports:
- wb_clk  in  1  system clock; all logic on rising edge.
- wb_rst  in  1  synchronous, active-high reset.
- wb_ibus_adr  in  32  ibus address.
- wb_ibus_cyc  in  1  ibus cycle.
- wb_ibus_stb  in  1  ibus strobe.
- wb_ibus_rdt  out  32  ibus read data.
- wb_ibus_ack  out  1  ibus ack.
- wb_ibus_err  out  1  ibus error.
- wb_dbus_adr  in  32  dbus address.
- wb_dbus_dat  in  32  dbus write data.
- wb_dbus_sel  in  4  dbus byte selects.
- wb_dbus_we  in  1  dbus write enable.
- wb_dbus_cyc  in  1  dbus cycle.
- wb_dbus_stb  in  1  dbus strobe.
- wb_dbus_rdt  out  32  dbus read data.
- wb_dbus_ack  out  1  dbus ack.
- wb_dbus_err  out  1  dbus error.
- wb_s_adr  out  32  slave address.
- wb_s_dat  out  32  slave write data.
- wb_s_sel  out  4  slave byte selects.
- wb_s_we  out  1  slave write enable.
- wb_s_cyc  out  1  slave cycle.
- wb_s_stb  out  1  slave strobe.
- wb_s_rdt  in  32  slave read data.
- wb_s_ack  in  1  slave ack.
- wb_s_err  in  1  slave error.
- grant  out  2  {dbus, ibus} one-hot current grant; 00 when idle.

Behaviour:
- Request definitions: req_i = wb_ibus_cyc & wb_ibus_stb; req_d = wb_dbus_cyc & wb_dbus_stb.
- FSM states: IDLE, GNT_I, GNT_D. Registers are state, last (0 = ibus, 1 = dbus) and to_cnt.
- Reset: state = IDLE, last = 0 (so the first tie goes to dbus), to_cnt = 0.
  - Outputs are then combinationally: grant = 00; wb_s_cyc/stb/we = 0; wb_s_adr/dat = 0; wb_s_sel = 0; all master ack/err = 0; rdt = 0.
- IDLE:
  - Only req_i -> GNT_I. Only req_d -> GNT_D.
  - Both -> grant the master not equal to last. Neither -> stay in IDLE.
  - Slave outputs are held at zero while in IDLE.
- Slave-side muxing in GNT_x is combinational from master x: adr, dat, sel, we, cyc, stb.
  - ibus drives we = 0, sel = 4'hF, dat = 0.
- Return-path routing:
  - wb_s_ack/err go only to the granted master; the other master's ack/err are 0.
  - wb_s_rdt drives the granted master's rdt; the other master's rdt is 0.
- Transfer end: in GNT_x, wb_s_ack | wb_s_err -> IDLE next cycle, last <= x, to_cnt <= 0.
- Latency: request seen in IDLE at cycle N gives wb_s_stb at N+1. A zero-wait ack at N+1 reaches the master at N+1. The arbiter is back in IDLE at N+2.
  - Minimum 2 cycles per transfer; no regrant directly from GNT_x.
- Master abort: in GNT_x, if cyc_x drops, wb_s_cyc/stb drop the same cycle (combinational).
  - Next state is IDLE, last <= x, to_cnt <= 0.
  - A slave ack in that same cycle is not forwarded.
- Timeout (TIMEOUT > 0):
  - to_cnt increments each GNT_x cycle with no slave ack/err.
  - The cycle in which to_cnt == TIMEOUT-1 and there is no ack/err:
    - wb_x_err = 1 for that single cycle;
    - wb_s_cyc/stb are forced to 0 that cycle;
    - next state IDLE, last <= x, to_cnt <= 0.
  - If ack arrives in the timeout cycle, ack wins and no err is generated.
- Simultaneous slave ack and err: both are forwarded as-is; the transfer ends.
- Reset asserted mid-transfer: state is IDLE next edge; no ack/err is forwarded after that edge; slave cyc drops.
- grant reflects state: GNT_I -> 01, GNT_D -> 10.

Test Plan:
- Single ibus read, slave acks in its first stb cycle:
  - ibus req at cycle 1 -> wb_s_stb=1, wb_s_adr=0x1000, we=0, sel=F at cycle 2;
  - wb_ibus_ack=1 and rdt=0xDEADBEEF at cycle 2; wb_dbus_ack=0 throughout;
  - grant=00 at cycle 3.
- Both masters request at the first cycle after reset, slave 1-wait:
  - dbus write is granted first (grant=10, wb_s_we=1, dat=0x12345678, sel=0x3);
  - ibus is granted on the following IDLE pass.
- Both masters request continuously for 6 transfers -> grant sequence D,I,D,I,D,I; each master receives exactly 3 acks.
- TIMEOUT=16, slave never acks, dbus request:
  - wb_dbus_err=1 on the 16th granted cycle with wb_s_cyc=0 that cycle;
  - then IDLE; a pending ibus request is granted next.
- dbus granted and slave stalling; dbus drops cyc at cycle 5:
  - wb_s_cyc=0 at cycle 5; IDLE at 6; pending ibus granted at 7; no dbus ack emitted.
- wb_rst=1 during a granted dbus transfer with slave ack at the same edge:
  - after the edge grant=00, all acks 0;
  - next tie goes to dbus (last=0).
